// File: rtl/xfer_seq_pkg.sv
// Shared encodings for the transfer sequencer: FSM states, op codes, register indices.
package xfer_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CALC    = 3'd1,
    S_WRITE   = 3'd2,
    S_BYTE_HI = 3'd3,
    S_BYTE_LO = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_COPY = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_ADD  = 2'b11
  } op_t;

  localparam int         NUM_REGS = 4;
  localparam logic [1:0] REG0     = 2'd0;
  localparam logic [1:0] REG1     = 2'd1;
  localparam logic [1:0] REG2     = 2'd2;
  localparam logic [1:0] REG3     = 2'd3;

  // Active-low one-cold strobe for the selected destination register.
  function automatic logic [NUM_REGS-1:0] load_mask_n(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/xfer_addr_calc.sv
// Combinational 16-bit copy / increment / decrement / add sign-extended offset, wrapping mod 2^16.
module xfer_addr_calc
  import xfer_seq_pkg::*;
(
  input  logic [15:0] operand,
  input  op_t         op,
  input  logic [7:0]  offset,
  output logic [15:0] result
);

  always_comb begin
    result = operand;
    case (op)
      OP_COPY: result = operand;
      OP_INC:  result = operand + 16'd1;
      OP_DEC:  result = operand - 16'd1;
      OP_ADD:  result = operand + {{8{offset[7]}}, offset};
      default: result = operand;
    endcase
  end

endmodule

// File: rtl/xfer_seq.sv
// Register-transfer sequencer: captures a request, computes the result, then loads the destination
// either as one 16-bit word on XferBus or as high/low bytes on MainBus. All strobes are registered.
module xfer_seq
  import xfer_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  output logic        ready,
  input  logic [1:0]  op,
  input  logic        split,
  input  logic [1:0]  src_sel,
  input  logic [1:0]  dst_sel,
  input  logic [7:0]  offset,
  input  logic [15:0] src0,
  input  logic [15:0] src1,
  input  logic [15:0] src2,
  input  logic [15:0] src3,
  output logic [15:0] XferBusOut,
  output logic [7:0]  MainBusOut,
  output logic        MainBusOE,
  output logic [3:0]  xfer_load_n,
  output logic [3:0]  main_high_load_n,
  output logic [3:0]  main_low_load_n,
  output logic        done
);

  state_t      state, next_state;
  logic [15:0] cap_src;
  op_t         cap_op;
  logic [7:0]  cap_off;
  logic        cap_split;
  logic [1:0]  cap_dst;
  logic [15:0] result;
  logic [15:0] calc_out;
  logic [15:0] src_mux;

  logic [3:0]  nxt_xfer_load_n, nxt_high_load_n, nxt_low_load_n;
  logic [7:0]  nxt_main_bus;
  logic        nxt_oe, nxt_done;

  always_comb begin
    src_mux = src0;
    case (src_sel)
      REG0:    src_mux = src0;
      REG1:    src_mux = src1;
      REG2:    src_mux = src2;
      REG3:    src_mux = src3;
      default: src_mux = src0;
    endcase
  end

  xfer_addr_calc u_calc (
    .operand (cap_src),
    .op      (cap_op),
    .offset  (cap_off),
    .result  (calc_out)
  );

  assign ready      = (state == S_IDLE);
  assign XferBusOut = result;

  // Outputs are decoded from the transition so they appear registered in the state they belong to.
  always_comb begin
    next_state      = state;
    nxt_xfer_load_n = 4'hF;
    nxt_high_load_n = 4'hF;
    nxt_low_load_n  = 4'hF;
    nxt_main_bus    = 8'h00;
    nxt_oe          = 1'b0;
    nxt_done        = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) next_state = S_CALC;
      end
      S_CALC: begin
        if (cap_split) begin
          next_state      = S_BYTE_HI;
          nxt_high_load_n = load_mask_n(cap_dst);
          nxt_main_bus    = calc_out[15:8];
          nxt_oe          = 1'b1;
        end else begin
          next_state      = S_WRITE;
          nxt_xfer_load_n = load_mask_n(cap_dst);
          nxt_done        = 1'b1;
        end
      end
      S_WRITE: begin
        next_state = S_IDLE;
      end
      S_BYTE_HI: begin
        next_state     = S_BYTE_LO;
        nxt_low_load_n = load_mask_n(cap_dst);
        nxt_main_bus   = result[7:0];
        nxt_oe         = 1'b1;
        nxt_done       = 1'b1;
      end
      S_BYTE_LO: begin
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      cap_src          <= 16'h0000;
      cap_op           <= OP_COPY;
      cap_off          <= 8'h00;
      cap_split        <= 1'b0;
      cap_dst          <= REG0;
      result           <= 16'h0000;
      xfer_load_n      <= 4'hF;
      main_high_load_n <= 4'hF;
      main_low_load_n  <= 4'hF;
      MainBusOut       <= 8'h00;
      MainBusOE        <= 1'b0;
      done             <= 1'b0;
    end else begin
      state            <= next_state;
      xfer_load_n      <= nxt_xfer_load_n;
      main_high_load_n <= nxt_high_load_n;
      main_low_load_n  <= nxt_low_load_n;
      MainBusOut       <= nxt_main_bus;
      MainBusOE        <= nxt_oe;
      done             <= nxt_done;
      if (state == S_IDLE && req) begin
        cap_src   <= src_mux;
        cap_op    <= op_t'(op);
        cap_off   <= offset;
        cap_split <= split;
        cap_dst   <= dst_sel;
      end
      if (state == S_CALC) result <= calc_out;
    end
  end

endmodule

// File: tb/tb_xfer_seq.sv
// Scoreboard bench for xfer_seq: expected strobe events are queued at request time and
// matched by a negedge monitor; scenario tasks add inline timing checks.
module tb_xfer_seq;

  logic        clk, rst, req, ready, split, MainBusOE, done;
  logic [1:0]  op, src_sel, dst_sel;
  logic [7:0]  offset, MainBusOut;
  logic [15:0] src0, src1, src2, src3, XferBusOut;
  logic [3:0]  xfer_load_n, main_high_load_n, main_low_load_n;

  typedef struct {
    int          kind;   // 0 word, 1 high byte, 2 low byte
    logic [15:0] val;
    logic [3:0]  strb;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   dones = 0;

  xfer_seq dut (
    .clk(clk), .rst(rst), .req(req), .ready(ready), .op(op), .split(split),
    .src_sel(src_sel), .dst_sel(dst_sel), .offset(offset),
    .src0(src0), .src1(src1), .src2(src2), .src3(src3),
    .XferBusOut(XferBusOut), .MainBusOut(MainBusOut), .MainBusOE(MainBusOE),
    .xfer_load_n(xfer_load_n), .main_high_load_n(main_high_load_n),
    .main_low_load_n(main_low_load_n), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model(input logic [15:0] s, input logic [1:0] o, input logic [7:0] off);
    logic [15:0] ext;
    ext = {{8{off[7]}}, off};
    case (o)
      2'b00:   return s;
      2'b01:   return s + 16'h0001;
      2'b10:   return s + 16'hFFFF;
      default: return s + ext;
    endcase
  endfunction

  function automatic logic [3:0] mask_n(input logic [1:0] d);
    logic [3:0] m;
    m = 4'b0000;
    m[d] = 1'b1;
    return ~m;
  endfunction

  function automatic logic [15:0] src_val(input logic [1:0] s);
    case (s)
      2'd0:    return src0;
      2'd1:    return src1;
      2'd2:    return src2;
      default: return src3;
    endcase
  endfunction

  task automatic push_exp(input logic sp, input logic [1:0] d, input logic [15:0] v);
    exp_t e;
    e.strb = mask_n(d);
    if (!sp) begin
      e.kind = 0; e.val = v; q.push_back(e);
    end else begin
      e.kind = 1; e.val = {8'h00, v[15:8]}; q.push_back(e);
      e.kind = 2; e.val = {8'h00, v[7:0]};  q.push_back(e);
    end
  endtask

  task automatic monitor();
    int          lows, kind;
    logic [15:0] val;
    logic [3:0]  strb;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (done) dones++;
        lows = $countones(~{xfer_load_n, main_high_load_n, main_low_load_n});
        total++;
        if (lows > 1) begin
          bad++;
          $display("FAIL strobe_onehot: got %b/%b/%b, need at most one low bit",
                   xfer_load_n, main_high_load_n, main_low_load_n);
        end
        if (lows == 1) begin
          if (xfer_load_n != 4'hF) begin
            kind = 0; val = XferBusOut; strb = xfer_load_n;
          end else if (main_high_load_n != 4'hF) begin
            kind = 1; val = {8'h00, MainBusOut}; strb = main_high_load_n;
          end else begin
            kind = 2; val = {8'h00, MainBusOut}; strb = main_low_load_n;
          end
          total++;
          if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_strobe: kind=%0d val=%h strb=%b, none expected", kind, val, strb);
          end else begin
            e = q.pop_front();
            if (kind !== e.kind || val !== e.val || strb !== e.strb) begin
              bad++;
              $display("FAIL scoreboard: got kind=%0d val=%h strb=%b, need kind=%0d val=%h strb=%b",
                       kind, val, strb, e.kind, e.val, e.strb);
            end
          end
          total++;
          if (done !== (kind != 1) || MainBusOE !== (kind != 0)) begin
            bad++;
            $display("FAIL strobe_ctrl: got done=%b oe=%b, need done=%b oe=%b",
                     done, MainBusOE, kind != 1, kind != 0);
          end
        end else begin
          total++;
          if (MainBusOE !== 1'b0 || MainBusOut !== 8'h00 || done !== 1'b0) begin
            bad++;
            $display("FAIL quiet_bus: got oe=%b bus=%h done=%b, need 0/00/0", MainBusOE, MainBusOut, done);
          end
        end
      end
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_timeout: got ready=%b, need 1", ready);
    end
  endtask

  task automatic drive_req(input logic [1:0] o, input logic sp, input logic [1:0] s, input logic [1:0] d,
                           input logic [7:0] off);
    op = o; split = sp; src_sel = s; dst_sel = d; offset = off; req = 1'b1;
  endtask

  task automatic do_xfer(input logic [1:0] o, input logic sp, input logic [1:0] s, input logic [1:0] d,
                         input logic [7:0] off, input logic [15:0] v);
    wait_ready();
    push_exp(sp, d, v);
    drive_req(o, sp, s, d, off);
    @(negedge clk); #1;
    req = 1'b0;
    wait_ready();
  endtask

  task automatic test_reset();
    total++;
    if (ready !== 1'b1 || done !== 1'b0 || MainBusOE !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got ready=%b done=%b oe=%b, need 1/0/0", ready, done, MainBusOE);
    end
    total++;
    if ({xfer_load_n, main_high_load_n, main_low_load_n} !== 12'hFFF) begin
      bad++;
      $display("FAIL reset_strobes: got %b/%b/%b, need all ones", xfer_load_n, main_high_load_n, main_low_load_n);
    end
    total++;
    if (XferBusOut !== 16'h0000 || MainBusOut !== 8'h00) begin
      bad++;
      $display("FAIL reset_buses: got xfer=%h main=%h, need 0000/00", XferBusOut, MainBusOut);
    end
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  // req presented in cycle n: CALC in n+1, strobe in n+2.
  task automatic test_word();
    wait_ready();
    src1 = 16'h1234;
    push_exp(1'b0, 2'd2, 16'h1235);
    drive_req(2'b01, 1'b0, 2'd1, 2'd2, 8'h00);
    @(negedge clk); #1;
    req = 1'b0;
    total++;
    if (ready !== 1'b0 || xfer_load_n !== 4'hF) begin
      bad++;
      $display("FAIL word_calc: got ready=%b xfer_load_n=%b, need 0/1111", ready, xfer_load_n);
    end
    @(negedge clk); #1;
    total++;
    if (XferBusOut !== 16'h1235 || xfer_load_n !== 4'b1011 || done !== 1'b1) begin
      bad++;
      $display("FAIL word_write: got %h/%b/%b, need 1235/1011/1", XferBusOut, xfer_load_n, done);
    end
    wait_ready();
  endtask

  task automatic test_arith();
    src0 = 16'hFFFF; src3 = 16'h0000; src2 = 16'h1000;
    do_xfer(2'b01, 1'b0, 2'd0, 2'd1, 8'h00, 16'h0000);
    do_xfer(2'b10, 1'b0, 2'd3, 2'd0, 8'h00, 16'hFFFF);
    do_xfer(2'b11, 1'b0, 2'd2, 2'd3, 8'h80, 16'h0F80);
    do_xfer(2'b11, 1'b1, 2'd2, 2'd2, 8'h7F, 16'h107F);
  endtask

  task automatic test_split();
    wait_ready();
    src0 = 16'hABCD;
    push_exp(1'b1, 2'd1, 16'hABCD);
    drive_req(2'b00, 1'b1, 2'd0, 2'd1, 8'h00);
    @(negedge clk); #1;
    req = 1'b0;
    @(negedge clk); #1;
    total++;
    if (MainBusOut !== 8'hAB || main_high_load_n !== 4'b1101 || MainBusOE !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL split_hi: got %h/%b/oe=%b/done=%b, need AB/1101/1/0",
               MainBusOut, main_high_load_n, MainBusOE, done);
    end
    @(negedge clk); #1;
    total++;
    if (MainBusOut !== 8'hCD || main_low_load_n !== 4'b1101 || done !== 1'b1) begin
      bad++;
      $display("FAIL split_lo: got %h/%b/done=%b, need CD/1101/1", MainBusOut, main_low_load_n, done);
    end
    wait_ready();
  endtask

  task automatic test_ignored_req();
    int d0;
    wait_ready();
    d0 = dones;
    src2 = 16'h0042; src3 = 16'h9999;
    push_exp(1'b0, 2'd0, 16'h0042);
    drive_req(2'b00, 1'b0, 2'd2, 2'd0, 8'h00);
    @(negedge clk); #1;
    drive_req(2'b01, 1'b1, 2'd3, 2'd3, 8'h00);
    @(negedge clk); #1;
    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("FAIL ignored_busy: got ready=%b, need 0", ready);
    end
    req = 1'b0;
    @(negedge clk); #1;
    total++;
    if (ready !== 1'b1 || dones - d0 != 1) begin
      bad++;
      $display("FAIL ignored_done: got ready=%b dones=%0d, need 1/1", ready, dones - d0);
    end
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int d0;
    wait_ready();
    src3 = 16'h5A5A;
    push_exp(1'b1, 2'd2, 16'h5A5A);
    drive_req(2'b00, 1'b1, 2'd3, 2'd2, 8'h00);
    @(negedge clk); #1;
    req = 1'b0;
    @(negedge clk); #2;
    d0 = dones;
    rst = 1'b1;
    #1;
    total++;
    if ({xfer_load_n, main_high_load_n, main_low_load_n} !== 12'hFFF || MainBusOE !== 1'b0 || ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid: got %b/%b/%b oe=%b ready=%b, need all ones/0/1",
               xfer_load_n, main_high_load_n, main_low_load_n, MainBusOE, ready);
    end
    total++;
    if (q.size() != 1) begin
      bad++;
      $display("FAIL reset_mid_queue: got %0d pending, need 1 (the aborted low byte)", q.size());
    end
    if (q.size() > 0) void'(q.pop_back());
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (dones != d0) begin
      bad++;
      $display("FAIL reset_mid_done: got %0d done pulses after reset, need 0", dones - d0);
    end
    src0 = 16'h0101;
    do_xfer(2'b10, 1'b1, 2'd0, 2'd3, 8'h00, 16'h0100);
  endtask

  task automatic test_same_sel();
    src3 = 16'h7FFF;
    do_xfer(2'b01, 1'b0, 2'd3, 2'd3, 8'h00, 16'h8000);
  endtask

  task automatic test_back_to_back();
    logic [1:0]  o, s, d;
    logic        sp;
    logic [7:0]  off;
    for (int i = 0; i < 8; i++) begin
      src0 = 16'($urandom); src1 = 16'($urandom); src2 = 16'($urandom); src3 = 16'($urandom);
      o = 2'($urandom_range(0, 3)); s = 2'($urandom_range(0, 3)); d = 2'($urandom_range(0, 3));
      sp = 1'($urandom_range(0, 1)); off = 8'($urandom);
      do_xfer(o, sp, s, d, off, model(src_val(s), o, off));
    end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; op = 2'b00; split = 1'b0; src_sel = 2'd0; dst_sel = 2'd0;
    offset = 8'h00; src0 = 16'h0; src1 = 16'h0; src2 = 16'h0; src3 = 16'h0;
    fork
      monitor();
    join_none
    #2;
    test_reset();
    test_word();
    test_arith();
    test_split();
    test_ignored_req();
    test_reset_mid();
    test_same_sel();
    test_back_to_back();
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d expected strobes never seen, need 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
